// File: rtl/serial_tx_pkg.sv
// ----------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and helpers for the serial_frame_tx transmitter.
//   tx_state_t   : transmitter FSM state encoding
//   frame_cycles : clock cycles occupied by one complete frame
// ----------------------------------------------------------------------------
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // p is 1 when a parity bit is part of the frame, else 0.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned stop_bits,
                                                 input int unsigned clks_per_bit,
                                                 input int unsigned p);
        return (1 + data_w + p + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer
// Modulo-CLKS_PER_BIT counter that marks the last clock of each serial bit.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clear_i : hold the counter at zero (no tick while asserted)
//   tick_o  : high on the final clock of the current bit period
// ----------------------------------------------------------------------------
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick_o = !clear_i && (cnt_q == Last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// ----------------------------------------------------------------------------
// serial_frame_tx
// Parallel-in / serial-out frame transmitter: start bit, DATA_W data bits,
// optional parity bit, STOP_BITS stop bits; every bit held CLKS_PER_BIT clocks.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   st      : start strobe, accepted when ready is high
//   data_in : payload, sampled only on the accepting edge
//   ready   : idle and able to accept st
//   tx      : registered serial line, idles high
//   done    : one-cycle pulse on the last clock of the last stop bit
// Build option: define SERIAL_FRAME_TX_PARITY_EN to insert a parity bit
// (^payload ^ PARITY_ODD) between the data and stop bits.
// ----------------------------------------------------------------------------
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned LSB_FIRST    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam int unsigned     IdxW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_W - 1);
    localparam logic            LastStop = 1'(STOP_BITS - 1);
    localparam bit              LsbFirst = (LSB_FIRST != 0);

    tx_state_t       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            stop_q, stop_d;
    logic            tx_q, tx_d;
    logic            tick;
    logic            timer_clr;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic            par_q, par_d;
`else
    logic            unused_parity_odd;
    assign unused_parity_odd = ^PARITY_ODD;
`endif

    // Timer is held at zero while idle so START always gets a full bit period.
    assign timer_clr = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (timer_clr),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (st) begin
                    shift_d = data_in;
                    idx_d   = '0;
                    stop_d  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = (^data_in) ^ 1'(PARITY_ODD);
`endif
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = LsbFirst ? (shift_q >> 1) : (shift_q << 1);
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_q == LastStop) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from next state so tx is a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = LsbFirst ? shift_d[0] : shift_d[DATA_W-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign ready = (state_q == IDLE);
    assign tx    = tx_q;
    assign done  = (state_q == STOP) && tick && (stop_q == LastStop);

endmodule

// File: tb/tb_serial_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_tx
// Directed bench for serial_frame_tx. Five instances share clk/reset:
//   0: DATA_W=4 CPB=1 LSB first          1: DATA_W=4 CPB=1 MSB first
//   2: defaults (8 bit, CPB=4)           3: DATA_W=4 CPB=1 STOP_BITS=2
//   4: DATA_W=4 CPB=1 LSB first, PARITY_ODD=1
// Expected tx sequences are written as vectors, bit i = serial bit i.
// ----------------------------------------------------------------------------
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int          P    = 1;
    localparam logic [15:0] E0   = 16'b111_0111_0;        // 0111 LSB, even parity 1
    localparam logic [15:0] E1   = 16'b111_1110_0;        // 0111 MSB, even parity 1
    localparam logic [15:0] E4   = 16'b100_1110;          // 0111 LSB, odd parity 0
    localparam logic [15:0] EA5  = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [15:0] E6   = 16'b111_0000;          // 1000 LSB, even parity 1
`else
    localparam int          P    = 0;
    localparam logic [15:0] E0   = 16'b10_1110;
    localparam logic [15:0] E1   = 16'b11_1100;
    localparam logic [15:0] E4   = 16'b10_1110;
    localparam logic [15:0] EA5  = {6'b0, 1'b1, 8'hA5, 1'b0};
    localparam logic [15:0] E6   = 16'b11_0000;
`endif
    localparam int N4  = 6 + P;            // serial bits, 4-bit payload, 1 stop
    localparam int NA5 = 10 + P;           // serial bits, 8-bit payload, 1 stop
    localparam int F3  = 7 + P;            // frame cycles, instance 3

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] st_v  = '0;
    logic [7:0] dat [5];
    logic [4:0] tx_w, rdy_w, done_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(1), .LSB_FIRST(1),
                      .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .st(st_v[0]), .data_in(dat[0][3:0]),
        .ready(rdy_w[0]), .tx(tx_w[0]), .done(done_w[0]));

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(1), .LSB_FIRST(0),
                      .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .st(st_v[1]), .data_in(dat[1][3:0]),
        .ready(rdy_w[1]), .tx(tx_w[1]), .done(done_w[1]));

    serial_frame_tx u_dut2 (
        .clk(clk), .reset(reset), .st(st_v[2]), .data_in(dat[2]),
        .ready(rdy_w[2]), .tx(tx_w[2]), .done(done_w[2]));

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2), .LSB_FIRST(1),
                      .PARITY_ODD(0)) u_dut3 (
        .clk(clk), .reset(reset), .st(st_v[3]), .data_in(dat[3][3:0]),
        .ready(rdy_w[3]), .tx(tx_w[3]), .done(done_w[3]));

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(1), .LSB_FIRST(1),
                      .PARITY_ODD(1)) u_dut4 (
        .clk(clk), .reset(reset), .st(st_v[4]), .data_in(dat[4][3:0]),
        .ready(rdy_w[4]), .tx(tx_w[4]), .done(done_w[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge right after the accepting edge.
    task automatic send(input int k, input logic [7:0] d);
        @(negedge clk);
        st_v[k] = 1'b1;
        dat[k]  = d;
        @(negedge clk);
        st_v[k] = 1'b0;
        dat[k]  = ~d;
    endtask

    // Follows send(); checks every cycle of the frame and the idle cycle after.
    task automatic expect_frame(input int k, input string tag, input logic [15:0] bits,
                                input int nbits, input int cpb);
        int last;
        last = nbits * cpb - 1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            check_eq($sformatf("%s c%0d tx", tag, c), 32'(tx_w[k]), 32'(bits[c / cpb]));
            check_eq($sformatf("%s c%0d done", tag, c), 32'(done_w[k]), 32'(c == last));
            check_eq($sformatf("%s c%0d ready", tag, c), 32'(rdy_w[k]), 32'd0);
        end
        @(negedge clk);
        check_eq({tag, " after ready"}, 32'(rdy_w[k]), 32'd1);
        check_eq({tag, " after tx"}, 32'(tx_w[k]), 32'd1);
        check_eq({tag, " after done"}, 32'(done_w[k]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) dat[k] = 8'h00;

        // 1. Reset held 3 clocks with st high on every instance.
        #1;
        reset = 1'b0;
        st_v  = 5'h1F;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst c%0d tx", c), 32'(tx_w), 32'h1F);
            check_eq($sformatf("rst c%0d ready", c), 32'(rdy_w), 32'h1F);
            check_eq($sformatf("rst c%0d done", c), 32'(done_w), 32'h0);
        end
        st_v  = '0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel tx", 32'(tx_w), 32'h1F);
        check_eq("rel ready", 32'(rdy_w), 32'h1F);
        check_eq("rel done", 32'(done_w), 32'h0);

        // 2. LSB first, 0111.
        send(0, 8'h07);
        expect_frame(0, "lsb0111", E0, N4, 1);

        // 3. MSB first, 0111; default params with A5 (40 cycles without parity).
        send(1, 8'h07);
        expect_frame(1, "msb0111", E1, N4, 1);
        send(2, 8'hA5);
        expect_frame(2, "defA5", EA5, NA5, 4);

        // 4. Odd-parity instance, 0111.
        send(4, 8'h07);
        expect_frame(4, "odd0111", E4, N4, 1);

        // 5. st held high, data changing every cycle, two stop bits.
        //    Accepts land on cycles 0, F3+1, 2*(F3+1); q is the position within a period.
        begin
            int kmax;
            int q;
            int drv;
            logic [3:0] w;
            logic       eb;
            kmax = 3 * (F3 + 1);
            for (int m = 0; m <= kmax; m++) begin
                if (m > 0) begin
                    q   = (m - 1) % (F3 + 1);
                    drv = m - 1 - q;
                    w   = 4'((drv * 5 + 3) & 15);
                    if (q == 0)                  eb = 1'b0;
                    else if (q <= 4)             eb = w[q-1];
                    else if (P == 1 && q == 5)   eb = ^w;
                    else                         eb = 1'b1;
                    check_eq($sformatf("b2b m%0d tx", m), 32'(tx_w[3]), 32'(eb));
                    check_eq($sformatf("b2b m%0d done", m), 32'(done_w[3]), 32'(q == F3 - 1));
                    check_eq($sformatf("b2b m%0d ready", m), 32'(rdy_w[3]), 32'(q == F3));
                end
                if (m < kmax) begin
                    st_v[3] = 1'b1;
                    dat[3]  = 8'((m * 5 + 3) & 15);
                    @(negedge clk);
                end else begin
                    st_v[3] = 1'b0;
                end
            end
        end

        // 6. Reset pulse in the middle of DATA, then a clean frame.
        send(0, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort tx", 32'(tx_w[0]), 32'd1);
        check_eq("abort ready", 32'(rdy_w[0]), 32'd1);
        check_eq("abort done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("post c%0d done", c), 32'(done_w[0]), 32'd0);
            check_eq($sformatf("post c%0d tx", c), 32'(tx_w[0]), 32'd1);
        end
        send(0, 8'h08);
        expect_frame(0, "lsb1000", E6, N4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
